steer_quad_ramp: RTL and testbench

//   Converts digital left/right steering (joystick/DB9/DB15) into a 2-bit quadrature

---
 rtl/steer_quad_ramp.sv | 167 ++++++++++++++++
 tb/tb_steer_quad_ramp.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/steer_quad_ramp.sv
// Digital left/right steering to a 2-bit Gray-code quadrature pair for sprint1.
// Holding a direction shortens the step period at every ramp point, down to a floor.
module steer_quad_ramp #(
    parameter int DIV_W      = 16,
    parameter int PERIOD_MAX = 22500,
    parameter int PERIOD_MIN = 5625,
    parameter int PERIOD_DEC = 2812,
    parameter int RAMP_STEPS = 16
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             ce,
    input  logic             left,
    input  logic             right,
    output logic             steer_a,
    output logic             steer_b,
    output logic             moving,
    output logic [DIV_W-1:0] period
);

    localparam int RAMP_W = (RAMP_STEPS > 1) ? $clog2(RAMP_STEPS) : 1;
    localparam logic [DIV_W-1:0] P_MAX     = DIV_W'(PERIOD_MAX);
    localparam logic [DIV_W-1:0] P_MIN     = DIV_W'(PERIOD_MIN);
    localparam logic [DIV_W-1:0] P_DEC     = DIV_W'(PERIOD_DEC);
    localparam logic [DIV_W:0]   P_FLOOR   = (DIV_W+1)'(PERIOD_MIN + PERIOD_DEC);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_R = 2'd1,
        RUN_L = 2'd2
    } state_t;

    // Gray-code step: right walks 00->01->11->10, left walks the reverse.
    function automatic logic [1:0] step_phase(input logic [1:0] ph, input logic fwd);
        logic [1:0] nxt;
        case (ph)
            2'b00:   nxt = fwd ? 2'b01 : 2'b10;
            2'b01:   nxt = fwd ? 2'b11 : 2'b00;
            2'b11:   nxt = fwd ? 2'b10 : 2'b01;
            2'b10:   nxt = fwd ? 2'b00 : 2'b11;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    // Shorten the period by one decrement, clamping at the floor without wrapping.
    function automatic logic [DIV_W-1:0] ramp_period(input logic [DIV_W-1:0] p);
        logic [DIV_W-1:0] nxt;
        if ({1'b0, p} <= P_FLOOR) begin
            nxt = P_MIN;
        end else begin
            nxt = p - P_DEC;
        end
        return nxt;
    endfunction

    logic              sync_l1_r, sync_l_r, sync_r1_r, sync_r_r;
    state_t            state_r, state_nxt_s;
    logic [1:0]        phase_r, phase_nxt_s;
    logic [DIV_W-1:0]  div_r, div_nxt_s;
    logic [DIV_W-1:0]  period_r, period_nxt_s;
    logic [RAMP_W-1:0] ramp_r, ramp_nxt_s;
    logic              moving_r;
    logic              dir_r_s, dir_l_s;

    assign dir_r_s = sync_r_r & ~sync_l_r;
    assign dir_l_s = sync_l_r & ~sync_r_r;

    // Next-state, divider, ramp and phase logic; everything holds while ce is low.
    always_comb begin
        state_nxt_s  = state_r;
        div_nxt_s    = div_r;
        ramp_nxt_s   = ramp_r;
        period_nxt_s = period_r;
        phase_nxt_s  = phase_r;
        if (ce) begin
            case (state_r)
                IDLE: begin
                    div_nxt_s    = '0;
                    ramp_nxt_s   = '0;
                    period_nxt_s = P_MAX;
                    if (dir_r_s) begin
                        state_nxt_s = RUN_R;
                    end else if (dir_l_s) begin
                        state_nxt_s = RUN_L;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                RUN_R, RUN_L: begin
                    if (!dir_r_s && !dir_l_s) begin
                        state_nxt_s  = IDLE;
                        div_nxt_s    = '0;
                        ramp_nxt_s   = '0;
                        period_nxt_s = P_MAX;
                    end else if ((state_r == RUN_R) == dir_l_s) begin
                        // Reversal restarts the ramp but keeps the phase continuous.
                        state_nxt_s  = dir_l_s ? RUN_L : RUN_R;
                        div_nxt_s    = '0;
                        ramp_nxt_s   = '0;
                        period_nxt_s = P_MAX;
                    end else if (div_r == period_r - DIV_W'(1)) begin
                        div_nxt_s   = '0;
                        phase_nxt_s = step_phase(phase_r, state_r == RUN_R);
                        if (ramp_r == RAMP_LAST) begin
                            ramp_nxt_s   = '0;
                            period_nxt_s = ramp_period(period_r);
                        end else begin
                            ramp_nxt_s = ramp_r + RAMP_W'(1);
                        end
                    end else begin
                        div_nxt_s = div_r + DIV_W'(1);
                    end
                end
                default: begin
                    state_nxt_s  = IDLE;
                    div_nxt_s    = '0;
                    ramp_nxt_s   = '0;
                    period_nxt_s = P_MAX;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Two-flop synchronisers for the asynchronous buttons; free-running, not ce-gated.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_l1_r <= 1'b0;
            sync_l_r  <= 1'b0;
            sync_r1_r <= 1'b0;
            sync_r_r  <= 1'b0;
        end else begin
            sync_l1_r <= left;
            sync_l_r  <= sync_l1_r;
            sync_r1_r <= right;
            sync_r_r  <= sync_r1_r;
        end
    end

    // FSM, counters, phase and registered status outputs.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r  <= IDLE;
            div_r    <= '0;
            ramp_r   <= '0;
            period_r <= P_MAX;
            phase_r  <= 2'b00;
            moving_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            div_r    <= div_nxt_s;
            ramp_r   <= ramp_nxt_s;
            period_r <= period_nxt_s;
            phase_r  <= phase_nxt_s;
            moving_r <= (state_nxt_s != IDLE);
        end
    end

    assign steer_a = phase_r[1];
    assign steer_b = phase_r[0];
    assign moving  = moving_r;
    assign period  = period_r;

endmodule

// File: tb/tb_steer_quad_ramp.sv
// Directed bench for steer_quad_ramp with small periods (MAX=8, MIN=2, DEC=2, 4 steps per ramp).
module tb_steer_quad_ramp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b1;
    logic        left = 1'b0;
    logic        right = 1'b0;
    logic        steer_a, steer_b, moving;
    logic [15:0] period;

    int errors = 0;
    int checks = 0;

    steer_quad_ramp #(
        .DIV_W(16), .PERIOD_MAX(8), .PERIOD_MIN(2), .PERIOD_DEC(2), .RAMP_STEPS(4)
    ) dut (
        .CLK(clk), .Reset_n(rst_n), .ce(ce), .left(left), .right(right),
        .steer_a(steer_a), .steer_b(steer_b), .moving(moving), .period(period)
    );

    always #5 clk = ~clk;

    // Count negedges until {a,b} changes (or bound expires, returning n = bound).
    task automatic measure_step(input int bound, output int n, output logic [1:0] ph);
        logic [1:0] prev;
        prev = {steer_a, steer_b};
        ph = prev;
        n = 0;
        while (n < bound) begin
            @(negedge clk);
            n++;
            if ({steer_a, steer_b} != prev) begin
                ph = {steer_a, steer_b};
                break;
            end
        end
    endtask

    task automatic wait_moving(input int bound, output int n);
        n = 0;
        while (n < bound && moving !== 1'b1) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; right = 1'b1; left = 1'b0; ce = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({steer_a, steer_b, moving} !== 3'b000) begin
                errors++;
                $display("FAIL reset_outs: got %b expected 000", {steer_a, steer_b, moving});
            end
            checks++;
            if (period !== 16'd8) begin
                errors++;
                $display("FAIL reset_period: got %0d expected 8", period);
            end
        end
    endtask

    task automatic test_ramp();
        logic [1:0] rseq [4];
        int n, gap, exp_p;
        logic [1:0] ph;
        rseq[0] = 2'b01; rseq[1] = 2'b11; rseq[2] = 2'b10; rseq[3] = 2'b00;
        rst_n = 1'b1;
        wait_moving(6, n);
        checks++;
        if (moving !== 1'b1) begin
            errors++;
            $display("FAIL ramp_moving: got %b expected 1 within 6 cycles", moving);
        end
        for (int i = 0; i < 20; i++) begin
            gap = (i < 16) ? 8 - 2 * (i / 4) : 2;
            measure_step(gap + 4, n, ph);
            checks++;
            if (n !== gap) begin
                errors++;
                $display("FAIL ramp_gap[%0d]: got %0d expected %0d", i, n, gap);
            end
            checks++;
            if (ph !== rseq[i % 4]) begin
                errors++;
                $display("FAIL ramp_phase[%0d]: got %b expected %b", i, ph, rseq[i % 4]);
            end
            if (i % 4 == 3) begin
                exp_p = 6 - 2 * (i / 4);
                if (exp_p < 2) exp_p = 2;
                checks++;
                if (period !== 16'(exp_p)) begin
                    errors++;
                    $display("FAIL ramp_period[%0d]: got %0d expected %0d", i, period, exp_p);
                end
            end
        end
    endtask

    task automatic test_reverse();
        int n;
        logic [1:0] ph;
        // Release at phase 00 with period 2: one more step lands before the sync catches up.
        right = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if ({moving, steer_a, steer_b} !== 3'b001 || period !== 16'd8) begin
            errors++;
            $display("FAIL idle_state: got m/ab=%b period=%0d expected 001 period=8",
                     {moving, steer_a, steer_b}, period);
        end
        right = 1'b1;
        wait_moving(6, n);
        measure_step(12, n, ph);
        checks++;
        if (n !== 8 || ph !== 2'b11) begin
            errors++;
            $display("FAIL rev_first_r: got gap=%0d ph=%b expected gap=8 ph=11", n, ph);
        end
        right = 1'b0; left = 1'b1;
        // 2 sync edges + 1 transition edge + 8 ticks in RUN_L
        measure_step(16, n, ph);
        checks++;
        if (n !== 11 || ph !== 2'b01) begin
            errors++;
            $display("FAIL rev_first_l: got gap=%0d ph=%b expected gap=11 ph=01", n, ph);
        end
        checks++;
        if (period !== 16'd8) begin
            errors++;
            $display("FAIL rev_period: got %0d expected 8", period);
        end
        measure_step(12, n, ph);
        checks++;
        if (n !== 8 || ph !== 2'b00) begin
            errors++;
            $display("FAIL rev_second_l: got gap=%0d ph=%b expected gap=8 ph=00", n, ph);
        end
        measure_step(12, n, ph);
        checks++;
        if (n !== 8 || ph !== 2'b10) begin
            errors++;
            $display("FAIL rev_third_l: got gap=%0d ph=%b expected gap=8 ph=10", n, ph);
        end
    endtask

    task automatic test_both_pressed();
        int changes;
        logic [1:0] prev;
        right = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (moving !== 1'b0 || period !== 16'd8) begin
            errors++;
            $display("FAIL both_idle: got moving=%b period=%0d expected 0/8", moving, period);
        end
        changes = 0;
        prev = {steer_a, steer_b};
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({steer_a, steer_b} != prev) changes++;
            prev = {steer_a, steer_b};
        end
        checks++;
        if (changes !== 0 || prev !== 2'b10) begin
            errors++;
            $display("FAIL both_frozen: got changes=%0d ph=%b expected 0 ph=10", changes, prev);
        end
    endtask

    task automatic test_ce_slow();
        int km, ks, changes;
        logic [1:0] prev;
        left = 1'b0; right = 1'b0;
        repeat (5) @(negedge clk);
        right = 1'b1;
        km = -1; ks = -1;
        for (int k = 0; k < 200 && ks < 0; k++) begin
            @(negedge clk);
            if (km < 0 && moving === 1'b1) km = k;
            if (km >= 0 && ks < 0 && {steer_a, steer_b} !== 2'b10) ks = k;
            ce = (k % 3 == 0);
        end
        checks++;
        if (km < 0 || ks - km !== 24) begin
            errors++;
            $display("FAIL ce_first_step: got km=%0d ks=%0d expected spacing 24", km, ks);
        end
        checks++;
        if ({steer_a, steer_b} !== 2'b00 || period !== 16'd8) begin
            errors++;
            $display("FAIL ce_step_value: got ph=%b period=%0d expected 00/8",
                     {steer_a, steer_b}, period);
        end
        ce = 1'b0;
        changes = 0;
        prev = {steer_a, steer_b};
        repeat (20) begin
            @(negedge clk);
            if ({steer_a, steer_b} != prev) changes++;
            prev = {steer_a, steer_b};
        end
        checks++;
        if (changes !== 0 || moving !== 1'b1 || period !== 16'd8) begin
            errors++;
            $display("FAIL ce_hold: got changes=%0d moving=%b period=%0d expected 0/1/8",
                     changes, moving, period);
        end
        ce = 1'b1;
    endtask

    task automatic test_reset_mid();
        int n, steps;
        logic [1:0] ph;
        steps = 0;
        while (period !== 16'd4 && steps < 10) begin
            measure_step(12, n, ph);
            steps++;
        end
        checks++;
        if (period !== 16'd4 || steps !== 7) begin
            errors++;
            $display("FAIL mid_reach4: got period=%0d steps=%0d expected 4/7", period, steps);
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({steer_a, steer_b, moving} !== 3'b000 || period !== 16'd8) begin
            errors++;
            $display("FAIL mid_async_reset: got abm=%b period=%0d expected 000/8",
                     {steer_a, steer_b, moving}, period);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_moving(6, n);
        checks++;
        if (moving !== 1'b1) begin
            errors++;
            $display("FAIL mid_restart: got moving=%b expected 1", moving);
        end
        measure_step(13, n, ph);
        checks++;
        if (n !== 8 || ph !== 2'b01) begin
            errors++;
            $display("FAIL mid_first_step: got gap=%0d ph=%b expected gap=8 ph=01", n, ph);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_reverse();
        test_both_pressed();
        test_ce_slow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
